cnn_conv_seq_ctrl: RTL and testbench

- Sequences one feature-map frame through the line-buffer + 5x5 `cnn_kernel` datapath.
- Accepts a raster pixel stream and tracks row/column position.
- Issues the kernel's window-valid strobe only for full-window positions.
- Counts kernel results and signals frame completion once all valid convolution outputs have drained.

---
 rtl/cnn_conv_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_cnn_conv_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_conv_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : cnn_conv_seq_ctrl
// Description : Frame sequencer for the line-buffer + KXxKY cnn_kernel path:
//               raster pixel intake, window-valid strobing, result drain.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cnn_conv_seq_ctrl #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int KX         = 5,
    parameter int KY         = 5,
    parameter int POS_BW     = 5,
    parameter int OUT_CNT_BW = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic                  i_pix_valid,
    output logic                  o_pix_ready,
    output logic                  o_win_valid,
    output logic [POS_BW-1:0]     o_row,
    output logic [POS_BW-1:0]     o_col,
    input  logic                  i_ker_ot_valid,
    output logic [OUT_CNT_BW-1:0] o_out_cnt,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int C_N_OUT = (IMG_H - KY + 1) * (IMG_W - KX + 1);

    localparam logic [POS_BW-1:0]     C_COL_LAST = POS_BW'(IMG_W - 1);
    localparam logic [POS_BW-1:0]     C_ROW_LAST = POS_BW'(IMG_H - 1);
    localparam logic [POS_BW-1:0]     C_COL_MIN  = POS_BW'(KX - 1);
    localparam logic [POS_BW-1:0]     C_ROW_MIN  = POS_BW'(KY - 1);
    localparam logic [POS_BW-1:0]     C_POS_ONE  = POS_BW'(1);
    localparam logic [OUT_CNT_BW-1:0] C_CNT_MAX  = OUT_CNT_BW'(C_N_OUT);
    localparam logic [OUT_CNT_BW-1:0] C_CNT_ONE  = OUT_CNT_BW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [POS_BW-1:0]     r_nrow;
    logic [POS_BW-1:0]     r_ncol;
    logic [POS_BW-1:0]     r_row;
    logic [POS_BW-1:0]     r_col;
    logic [OUT_CNT_BW-1:0] r_cnt;
    logic                  r_win;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic w_accept;
    logic w_last_pix;
    logic w_full_win;
    logic w_cnt_full;
    logic w_counting;
    logic w_cnt_inc;
    logic w_err_set;
    logic w_start;

    assign o_pix_ready = (r_state == S_RUN);
    assign w_accept    = i_pix_valid && o_pix_ready;
    assign w_start     = (r_state == S_IDLE) && i_start;

    // r_nrow/r_ncol hold the coordinates the next accepted pixel will take
    assign w_last_pix  = (r_nrow == C_ROW_LAST) && (r_ncol == C_COL_LAST);
    assign w_full_win  = (r_nrow >= C_ROW_MIN) && (r_ncol >= C_COL_MIN);

    assign w_cnt_full  = (r_cnt == C_CNT_MAX);
    assign w_counting  = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_cnt_inc   = i_ker_ot_valid && w_counting && !w_cnt_full;
    // Any result the controller cannot account for is an error
    assign w_err_set   = i_ker_ot_valid && !w_cnt_inc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (w_accept && w_last_pix) w_next = S_DRAIN;
            S_DRAIN: if (w_cnt_full) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_win   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_RUN) || (w_next == S_DRAIN);
            r_done  <= (w_next == S_DONE);
            r_win   <= w_accept && w_full_win;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nrow <= '0;
            r_ncol <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_start) begin
            r_nrow <= '0;
            r_ncol <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_accept) begin
            r_row <= r_nrow;
            r_col <= r_ncol;
            if (r_ncol == C_COL_LAST) begin
                r_ncol <= '0;
                r_nrow <= r_nrow + C_POS_ONE;
            end else begin
                r_ncol <= r_ncol + C_POS_ONE;
            end
        end
    end

    // Start clears the result bookkeeping even if a stray result coincides
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_start) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_cnt_inc) r_cnt <= r_cnt + C_CNT_ONE;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign o_win_valid = r_win;
    assign o_row       = r_row;
    assign o_col       = r_col;
    assign o_out_cnt   = r_cnt;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cnn_conv_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_cnn_conv_seq_ctrl
// Description : Randomised frame bench for cnn_conv_seq_ctrl with a
//               pixel-count reference model and a 2-cycle kernel echo.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cnn_conv_seq_ctrl;

    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int KX         = 5;
    localparam int KY         = 5;
    localparam int POS_BW     = 5;
    localparam int OUT_CNT_BW = 10;
    localparam int N_OUT      = (IMG_H - KY + 1) * (IMG_W - KX + 1);
    localparam int N_PIX      = IMG_W * IMG_H;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  i_start = 1'b0;
    logic                  i_pix_valid = 1'b0;
    logic                  o_pix_ready;
    logic                  o_win_valid;
    logic [POS_BW-1:0]     o_row;
    logic [POS_BW-1:0]     o_col;
    logic                  i_ker_ot_valid;
    logic [OUT_CNT_BW-1:0] o_out_cnt;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    logic       r_spur = 1'b0;
    logic [1:0] r_kq;

    int n_chk = 0;
    int n_err = 0;

    int win_cnt = 0;
    int done_cnt = 0;
    bit seen_first = 0;
    int last_wr = -1;
    int last_wc = -1;

    cnn_conv_seq_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .KX(KX), .KY(KY),
        .POS_BW(POS_BW), .OUT_CNT_BW(OUT_CNT_BW)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_pix_valid   (i_pix_valid),
        .o_pix_ready   (o_pix_ready),
        .o_win_valid   (o_win_valid),
        .o_row         (o_row),
        .o_col         (o_col),
        .i_ker_ot_valid(i_ker_ot_valid),
        .o_out_cnt     (o_out_cnt),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    // Kernel stand-in: echoes the window strobe two cycles later
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_kq <= 2'b00;
        else          r_kq <= {r_kq[0], o_win_valid};
    end
    assign i_ker_ot_valid = r_kq[1] | r_spur;

    function automatic void chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: phase 0 idle, 1 taking pixels, 2 waiting for results, 3 done
    int m_ph, m_acc, m_row, m_col, m_cnt;
    bit m_win, m_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph <= 0; m_acc <= 0; m_row <= 0; m_col <= 0;
            m_cnt <= 0; m_win <= 1'b0; m_err <= 1'b0;
        end else begin
            m_win <= 1'b0;
            case (m_ph)
                0: begin
                    if (i_start) begin
                        m_ph <= 1; m_acc <= 0; m_row <= 0; m_col <= 0;
                        m_cnt <= 0; m_err <= 1'b0;
                    end else if (i_ker_ot_valid) begin
                        m_err <= 1'b1;
                    end
                end
                1, 2: begin
                    if (i_ker_ot_valid) begin
                        if (m_cnt == N_OUT) m_err <= 1'b1;
                        else                m_cnt <= m_cnt + 1;
                    end
                    if (m_ph == 1 && i_pix_valid) begin
                        m_row <= m_acc / IMG_W;
                        m_col <= m_acc % IMG_W;
                        m_win <= (m_acc / IMG_W >= KY - 1) && (m_acc % IMG_W >= KX - 1);
                        m_acc <= m_acc + 1;
                        if (m_acc == N_PIX - 1) m_ph <= 2;
                    end
                    if (m_ph == 2 && m_cnt == N_OUT) m_ph <= 3;
                end
                default: begin
                    if (i_ker_ot_valid) m_err <= 1'b1;
                    m_ph <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("pix_ready", int'(o_pix_ready), int'(m_ph == 1));
        chk("win_valid", int'(o_win_valid), int'(m_win));
        chk("row",       int'(o_row),       m_row);
        chk("col",       int'(o_col),       m_col);
        chk("out_cnt",   int'(o_out_cnt),   m_cnt);
        chk("busy",      int'(o_busy),      int'(m_ph == 1 || m_ph == 2));
        chk("done",      int'(o_done),      int'(m_ph == 3));
        chk("err",       int'(o_err),       int'(m_err));
        if (o_win_valid) begin
            win_cnt++;
            chk("win_col_min", int'(o_col >= 4), 1);
            if (!seen_first) begin
                seen_first = 1;
                chk("first_win_row", int'(o_row), 4);
                chk("first_win_col", int'(o_col), 4);
            end
            last_wr = int'(o_row);
            last_wc = int'(o_col);
        end
        if (o_done) done_cnt++;
    end

    task automatic run_frame(input int gap_pct, input int start_pix, input int rst_pix);
        int sent;
        int guard;
        sent = 0;
        guard = 0;
        @(posedge clk); #1;
        i_start = 1'b1;
        win_cnt = 0; done_cnt = 0; seen_first = 0; last_wr = -1; last_wc = -1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        chk("start_clr_err", int'(o_err), 0);
        chk("start_clr_cnt", int'(o_out_cnt), 0);
        while (sent < N_PIX && guard < 20 * N_PIX) begin
            @(posedge clk); #1;
            guard++;
            if (sent == rst_pix) begin
                reset_n = 1'b0;
                i_pix_valid = 1'b0;
                i_start = 1'b0;
                @(negedge clk);
                chk("midrst_busy", int'(o_busy), 0);
                chk("midrst_row", int'(o_row), 0);
                chk("midrst_cnt", int'(o_out_cnt), 0);
                chk("midrst_ready", int'(o_pix_ready), 0);
                repeat (2) @(posedge clk);
                #1 reset_n = 1'b1;
                return;
            end
            i_pix_valid = ($urandom_range(0, 99) >= gap_pct);
            i_start = (sent == start_pix);
            @(negedge clk);
            if (i_pix_valid && o_pix_ready) sent++;
        end
        @(posedge clk); #1;
        i_pix_valid = 1'b0;
        i_start = 1'b0;
        chk("pix_budget", sent, N_PIX);
        guard = 0;
        while (done_cnt == 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("done_timeout", int'(done_cnt > 0), 1);
        repeat (3) @(negedge clk);
        chk("frame_win_cnt", win_cnt, 576);
        chk("frame_done_cnt", done_cnt, 1);
        chk("frame_out_cnt", int'(o_out_cnt), 576);
        chk("frame_busy", int'(o_busy), 0);
        chk("frame_err", int'(o_err), 0);
        chk("last_win_row", last_wr, 27);
        chk("last_win_col", last_wc, 27);
    endtask

    initial begin
        reset_n = 1'b0;
        i_pix_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(o_pix_ready), 0);
        chk("rst_cnt", int'(o_out_cnt), 0);
        chk("rst_busy", int'(o_busy), 0);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", int'(o_pix_ready), 0);
        chk("idle_row", int'(o_row), 0);
        chk("idle_col", int'(o_col), 0);
        @(posedge clk); #1 i_pix_valid = 1'b0;

        run_frame(0, -1, -1);
        run_frame(30, -1, -1);

        @(posedge clk); #1 r_spur = 1'b1;
        @(posedge clk); #1 r_spur = 1'b0;
        @(negedge clk);
        chk("spur_err", int'(o_err), 1);
        chk("spur_cnt", int'(o_out_cnt), 576);

        run_frame(20, 300, -1);
        run_frame(10, -1, 400);
        repeat (2) @(negedge clk);
        chk("post_rst_busy", int'(o_busy), 0);
        chk("post_rst_ready", int'(o_pix_ready), 0);
        run_frame(0, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
